cpu_commit_stage: RTL and testbench

- Pipeline stage after execute. Receives the execute-stage results: ALU result, store data, destination register, writeback and commit controls.
- Performs data-memory loads and stores over a single-outstanding req/ack handshake to the data memory, and stalls the front of the pipeline while an access is pending.
- Registers results toward writeback. Exposes the in-flight instruction to the forwarding unit (commit bypass) and the hazard unit (load-use).

---
 rtl/cpu_commit_stage.sv | 152 +++++++++++++++
 tb/tb_cpu_commit_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cpu_commit_stage.sv
// Commit stage: sits after execute, runs data-memory loads/stores over a
// single-outstanding req/ack handshake, registers results toward writeback
// and exposes the in-flight instruction to forwarding and hazard logic.
module cpu_commit_stage #(
  parameter int REG_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [REG_ID_WIDTH-1:0] in_reg_dest,
  input  logic                    in_reg_write,
  input  logic                    in_mem_read,
  input  logic                    in_mem_write,
  input  logic [REG_WIDTH-1:0]    in_alu_result,
  input  logic [REG_WIDTH-1:0]    in_rb_data,
  output logic                    stall,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_WIDTH-1:0]   dmem_addr,
  output logic [REG_WIDTH-1:0]    dmem_wdata,
  input  logic [REG_WIDTH-1:0]    dmem_rdata,
  input  logic                    dmem_ack,
  output logic [REG_ID_WIDTH-1:0] fw_reg_dest,
  output logic                    fw_reg_write,
  output logic [REG_WIDTH-1:0]    fw_value,
  output logic                    hd_mem_read,
  output logic                    wb_valid,
  output logic                    wb_reg_write,
  output logic [REG_ID_WIDTH-1:0] wb_reg_dest,
  output logic [REG_WIDTH-1:0]    wb_value,
  output logic                    mem_misaligned
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic                    memop, mis;
  logic                    req_d, we_d, wb_valid_d, wb_reg_write_d, mis_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [REG_WIDTH-1:0]    wdata_d, wb_value_d;
  logic [REG_ID_WIDTH-1:0] wb_reg_dest_d;
  logic [REG_ID_WIDTH-1:0] lat_dest, lat_dest_d;
  logic                    lat_reg_write, lat_reg_write_d;
  logic                    lat_load, lat_load_d;

  assign memop = in_valid & (in_mem_read | in_mem_write);
  assign mis   = memop & (in_alu_result[1:0] != 2'b00);

  // Front-end hold: while accepting a memop and until the ack arrives.
  always_comb begin
    stall = ((state_q == IDLE) & memop & ~mis) | ((state_q == WAIT) & ~dmem_ack);
  end

  // Bypass / hazard visibility of the instruction currently presented.
  always_comb begin
    fw_reg_dest  = in_reg_dest;
    fw_reg_write = in_valid & in_reg_write & ~in_mem_read & ~stall;
    fw_value     = in_alu_result;
    hd_mem_read  = in_valid & in_mem_read;
  end

  // Next-state and next-output computation for all registered state.
  always_comb begin
    state_d         = state_q;
    req_d           = dmem_req;
    we_d            = dmem_we;
    addr_d          = dmem_addr;
    wdata_d         = dmem_wdata;
    wb_valid_d      = 1'b0;
    wb_reg_write_d  = wb_reg_write;
    wb_reg_dest_d   = wb_reg_dest;
    wb_value_d      = wb_value;
    mis_d           = 1'b0;
    lat_dest_d      = lat_dest;
    lat_reg_write_d = lat_reg_write;
    lat_load_d      = lat_load;
    case (state_q)
      IDLE: begin
        if (memop && !mis) begin
          state_d         = WAIT;
          req_d           = 1'b1;
          we_d            = in_mem_write;
          addr_d          = in_alu_result[ADDR_WIDTH-1:0];
          wdata_d         = in_rb_data;
          wb_reg_write_d  = 1'b0;
          lat_dest_d      = in_reg_dest;
          lat_reg_write_d = in_reg_write;
          // read+write together behaves as a store
          lat_load_d      = in_mem_read & ~in_mem_write;
        end else begin
          wb_valid_d     = in_valid;
          wb_reg_write_d = in_valid & in_reg_write & ~in_mem_read & ~in_mem_write;
          wb_reg_dest_d  = in_reg_dest;
          wb_value_d     = in_alu_result;
          mis_d          = mis;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d       = IDLE;
          req_d         = 1'b0;
          wb_valid_d    = 1'b1;
          wb_reg_dest_d = lat_dest;
          if (lat_load) begin
            wb_value_d     = dmem_rdata;
            wb_reg_write_d = lat_reg_write;
          end else begin
            wb_value_d     = '0;
            wb_reg_write_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_reg_dest    <= '0;
      wb_value       <= '0;
      mem_misaligned <= 1'b0;
      lat_dest       <= '0;
      lat_reg_write  <= 1'b0;
      lat_load       <= 1'b0;
    end else begin
      state_q        <= state_d;
      dmem_req       <= req_d;
      dmem_we        <= we_d;
      dmem_addr      <= addr_d;
      dmem_wdata     <= wdata_d;
      wb_valid       <= wb_valid_d;
      wb_reg_write   <= wb_reg_write_d;
      wb_reg_dest    <= wb_reg_dest_d;
      wb_value       <= wb_value_d;
      mem_misaligned <= mis_d;
      lat_dest       <= lat_dest_d;
      lat_reg_write  <= lat_reg_write_d;
      lat_load       <= lat_load_d;
    end
  end

endmodule

// File: tb/tb_cpu_commit_stage.sv
// Directed testbench for cpu_commit_stage with hand-computed expectations.
module tb_cpu_commit_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_reg_write, in_mem_read, in_mem_write;
  logic [4:0]  in_reg_dest;
  logic [31:0] in_alu_result, in_rb_data;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  fw_reg_dest, wb_reg_dest;
  logic        fw_reg_write, hd_mem_read, wb_valid, wb_reg_write, mem_misaligned;
  logic [31:0] fw_value, wb_value;

  int checks = 0;
  int errors = 0;

  cpu_commit_stage #(.REG_WIDTH(32), .ADDR_WIDTH(32), .REG_ID_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_reg_dest(in_reg_dest), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_alu_result(in_alu_result), .in_rb_data(in_rb_data),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .fw_reg_dest(fw_reg_dest), .fw_reg_write(fw_reg_write), .fw_value(fw_value),
    .hd_mem_read(hd_mem_read),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_reg_dest(wb_reg_dest), .wb_value(wb_value),
    .mem_misaligned(mem_misaligned)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_reg_dest = '0; in_alu_result = '0; in_rb_data = '0;
  endtask

  // Present a memop, hold it while stalled, ack after n waiting cycles.
  task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] dest, input logic [31:0] rdata, input int n);
    in_valid = 1'b1; in_reg_write = ~we; in_mem_read = ~we; in_mem_write = we;
    in_reg_dest = dest; in_alu_result = addr; in_rb_data = wdata;
    #1;
    check("accept_stall", {31'b0, stall}, 32'd1);
    check("accept_hd", {31'b0, hd_mem_read}, {31'b0, ~we});
    check("accept_fw", {31'b0, fw_reg_write}, 32'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      check("wait_req", {31'b0, dmem_req}, 32'd1);
      check("wait_addr", dmem_addr, addr);
      check("wait_we", {31'b0, dmem_we}, {31'b0, we});
      check("wait_stall", {31'b0, stall}, 32'd1);
      check("wait_wbv", {31'b0, wb_valid}, 32'd0);
      tick();
    end
    check("ack_req", {31'b0, dmem_req}, 32'd1);
    check("ack_addr", dmem_addr, addr);
    check("ack_we", {31'b0, dmem_we}, {31'b0, we});
    if (we) check("ack_wdata", dmem_wdata, wdata);
    dmem_ack = 1'b1; dmem_rdata = rdata;
    #1;
    check("ack_stall", {31'b0, stall}, 32'd0);
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    idle_inputs();
    check("done_req", {31'b0, dmem_req}, 32'd0);
    check("done_wbv", {31'b0, wb_valid}, 32'd1);
    check("done_wbw", {31'b0, wb_reg_write}, {31'b0, ~we});
    check("done_dest", {27'b0, wb_reg_dest}, {27'b0, dest});
    check("done_val", wb_value, we ? 32'd0 : rdata);
  endtask

  initial begin
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    idle_inputs();
    tick(); tick();
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_wbv", {31'b0, wb_valid}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_val", wb_value, 32'd0);
    check("rst_mis", {31'b0, mem_misaligned}, 32'd0);
    reset = 1'b0;
    tick();

    // ALU passthrough
    in_valid = 1'b1; in_reg_write = 1'b1; in_reg_dest = 5'd5; in_alu_result = 32'h2A;
    #1;
    check("alu_fw_we", {31'b0, fw_reg_write}, 32'd1);
    check("alu_fw_val", fw_value, 32'h2A);
    check("alu_stall", {31'b0, stall}, 32'd0);
    tick();
    idle_inputs();
    check("alu_wbv", {31'b0, wb_valid}, 32'd1);
    check("alu_wbw", {31'b0, wb_reg_write}, 32'd1);
    check("alu_dest", {27'b0, wb_reg_dest}, 32'd5);
    check("alu_val", wb_value, 32'h2A);
    tick();
    check("alu_wbv_off", {31'b0, wb_valid}, 32'd0);

    // Load with 3-cycle memory
    mem_op(1'b0, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 2);
    tick();
    check("ld_wbv_off", {31'b0, wb_valid}, 32'd0);

    // Store, zero-wait ack
    mem_op(1'b1, 32'h20, 32'h1234, 5'd3, 32'hFFFF_FFFF, 0);
    tick();

    // Misaligned load
    in_valid = 1'b1; in_mem_read = 1'b1; in_reg_write = 1'b1;
    in_reg_dest = 5'd9; in_alu_result = 32'h103;
    #1;
    check("mis_stall", {31'b0, stall}, 32'd0);
    tick();
    idle_inputs();
    check("mis_req", {31'b0, dmem_req}, 32'd0);
    check("mis_pulse", {31'b0, mem_misaligned}, 32'd1);
    check("mis_wbv", {31'b0, wb_valid}, 32'd1);
    check("mis_wbw", {31'b0, wb_reg_write}, 32'd0);
    tick();
    check("mis_pulse_end", {31'b0, mem_misaligned}, 32'd0);
    check("mis_req2", {31'b0, dmem_req}, 32'd0);

    // Back-to-back loads; done_req inside mem_op shows the low gap
    mem_op(1'b0, 32'h10, 32'h0, 5'd11, 32'hA5A5_0001, 1);
    mem_op(1'b0, 32'h14, 32'h0, 5'd12, 32'h5A5A_0002, 1);
    tick();

    // Reset mid-access, then a stray ack
    in_valid = 1'b1; in_mem_read = 1'b1; in_reg_write = 1'b1;
    in_reg_dest = 5'd4; in_alu_result = 32'h40;
    tick();
    check("rma_req", {31'b0, dmem_req}, 32'd1);
    tick();
    reset = 1'b1; idle_inputs();
    tick();
    reset = 1'b0;
    check("rma_req_drop", {31'b0, dmem_req}, 32'd0);
    check("rma_stall", {31'b0, stall}, 32'd0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    #1;
    check("stray_stall", {31'b0, stall}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    check("stray_wbv", {31'b0, wb_valid}, 32'd0);
    check("stray_req", {31'b0, dmem_req}, 32'd0);
    check("stray_val", wb_value, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
